// File: rtl/mc_controller.sv
// mc_controller: multicycle RISC-V control unit (Moore FSM plus ALU and
// immediate decoders).
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a
// sticky ILLEGAL state. Otherwise unknown opcodes fall back to FETCH and
// illegal stays 0.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
`ifdef MC_ILLEGAL_TRAP_EN
    , S_ILLEGAL
`endif
  } state_e;

  state_e     state_q, state_d;
  state_e     out_state;
  logic [1:0] aluop;
  logic       branch, pcupdate;
  logic       irwrite_s, regwrite_s, memwrite_s, illegal_s;

  // State register; reset wins over any pending transition
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; op only matters in DECODE and MEMADR
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_ILLEGAL;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // While reset is held, outputs present FETCH values (enables gated below)
  assign out_state = reset ? S_FETCH : state_q;

  // Moore outputs decoded from the displayed state
  always_comb begin
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    resultsrc  = 2'b00;
    adrsrc     = 1'b0;
    irwrite_s  = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    illegal_s  = 1'b0;
    case (out_state)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite_s = 1'b1;
        pcupdate  = 1'b1;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMREAD:  adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      S_ALUWB:    regwrite_s = 1'b1;
      S_BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_ILLEGAL:  illegal_s = 1'b1;
`endif
      default: ;
    endcase
  end

  // Write enables and the trap flag are forced low during reset
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign pcwrite  = (pcupdate | (branch & zero)) & ~reset;
  assign illegal  = illegal_s  & ~reset;

  // ALU decoder; subtract for R-type only when funct7b5 is set
  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b01: alucontrol = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Immediate format follows the live opcode in every state
  always_comb begin
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus side expands each
// instruction into its sequence of control steps and queues the expected
// outputs; the monitor compares them on the falling edge.
module tb_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  // control steps of an instruction
  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5,
                 S_ER = 6, S_EI = 7, S_AWB = 8, S_BEQ = 9, S_JAL = 10,
                 S_ILL = 11, S_RST = 12;
  // instruction classes
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5,
                 C_BAD = 6;

  typedef struct packed {
    logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite, pcwrite, regwrite, memwrite, illegal;
  } exp_t;

  typedef struct {
    exp_t e;
    int   step;
    int   cyc;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite, illegal;

  item_t q[$];
  int    errors = 0, checks = 0, pushed = 0, ncyc = 0;
  bit    done = 1'b0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .adrsrc(adrsrc), .alucontrol(alucontrol),
    .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
    .memwrite(memwrite), .illegal(illegal)
  );

  // Expected outputs for one step of an instruction, from the control table
  function automatic exp_t model(input int s, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7,
                                 input logic z);
    exp_t e;
    logic [1:0] aluop;
    e = '0;
    aluop = 2'b00;
    if (o == SW)      e.immsrc = 2'b01;
    else if (o == BQ) e.immsrc = 2'b10;
    else if (o == JL) e.immsrc = 2'b11;
    case (s)
      S_RST: begin e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
      S_F:   begin e.alusrcb = 2'b10; e.resultsrc = 2'b10;
                   e.irwrite = 1'b1; e.pcwrite = 1'b1; end
      S_D:   begin e.alusrca = 2'b01; e.alusrcb = 2'b01; end
      S_MA:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
      S_MR:  e.adrsrc = 1'b1;
      S_MWB: begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
      S_MW:  begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
      S_ER:  begin e.alusrca = 2'b10; aluop = 2'b10; end
      S_EI:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; aluop = 2'b10; end
      S_AWB: e.regwrite = 1'b1;
      S_BEQ: begin e.alusrca = 2'b10; aluop = 2'b01; e.pcwrite = z; end
      S_JAL: begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
      S_ILL: e.illegal = 1'b1;
      default: ;
    endcase
    if (aluop == 2'b01) e.alucontrol = 3'b001;
    else if (aluop == 2'b10) begin
      if (f3 == 3'b000)      e.alucontrol = (o[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.alucontrol = 3'b101;
      else if (f3 == 3'b110) e.alucontrol = 3'b011;
      else if (f3 == 3'b111) e.alucontrol = 3'b010;
    end
    return e;
  endfunction

  // One clock cycle: drive inputs, queue the expectation, advance
  task automatic cyc(input int s, input logic rst, input logic [6:0] o,
                     input logic [2:0] f3, input logic f7, input logic z);
    item_t it;
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
    it.e = model(rst ? S_RST : s, o, f3, f7, z);
    it.step = rst ? S_RST : s;
    it.cyc = ncyc;
    q.push_back(it);
    pushed++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] class_op(input int cls);
    logic [6:0] o;
    case (cls)
      C_LW:  o = LW;
      C_SW:  o = SW;
      C_R:   o = RT;
      C_I:   o = IT;
      C_BEQ: o = BQ;
      C_JAL: o = JL;
      default: begin
        o = 7'($urandom);
        while (o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL)
          o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  // Run one instruction. cut>=0 asserts reset in place of that step.
  // hold keeps op steady throughout; otherwise op is only stable where it
  // is sampled. f3/f7/z < 0 mean randomize each cycle.
  task automatic run(input int cls, input int cut, input bit hold,
                     input int f3, input int f7, input int z);
    int steps[$];
    logic [6:0] iop, o;
    logic [2:0] a3;
    logic a7, az;
    iop = class_op(cls);
    case (cls)
      C_LW:  steps = {S_F, S_D, S_MA, S_MR, S_MWB};
      C_SW:  steps = {S_F, S_D, S_MA, S_MW};
      C_R:   steps = {S_F, S_D, S_ER, S_AWB};
      C_I:   steps = {S_F, S_D, S_EI, S_AWB};
      C_BEQ: steps = {S_F, S_D, S_BEQ};
      C_JAL: steps = {S_F, S_D, S_JAL, S_AWB};
`ifdef MC_ILLEGAL_TRAP_EN
      default: begin
        steps = {S_F, S_D, S_ILL, S_ILL, S_ILL};
        if (cut < 0 || cut >= 5) cut = 5;   // the trap only leaves via reset
      end
`else
      default: steps = {S_F, S_D};
`endif
    endcase
    for (int i = 0; i <= steps.size(); i++) begin
      a3 = (f3 < 0) ? 3'($urandom) : 3'(f3);
      a7 = (f7 < 0) ? 1'($urandom) : 1'(f7);
      az = (z  < 0) ? 1'($urandom) : 1'(z);
      if (i == cut) begin
        cyc(S_RST, 1'b1, 7'($urandom), a3, a7, az);
        return;
      end
      if (i == steps.size()) return;
      o = (hold || steps[i] == S_D || steps[i] == S_MA) ? iop : 7'($urandom);
      cyc(steps[i], 1'b0, o, a3, a7, az);
    end
  endtask

  // Stimulus
  initial begin
    int cls, cut;
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    cyc(S_RST, 1'b1, LW, 3'b000, 1'b0, 1'b0);
    cyc(S_RST, 1'b1, LW, 3'b000, 1'b0, 1'b0);
    // directed cases
    run(C_LW,  -1, 1'b1, -1, -1, -1);
    run(C_BEQ, -1, 1'b1, -1, -1, 1);
    run(C_BEQ, -1, 1'b1, -1, -1, 0);
    run(C_R,   -1, 1'b1, 0, 1, -1);
    run(C_R,   -1, 1'b1, 7, 0, -1);
    run(C_SW,  -1, 1'b1, -1, -1, -1);
    run(C_LW,   3, 1'b1, -1, -1, -1);   // reset while in MEMREAD
    run(C_LW,  -1, 1'b1, -1, -1, -1);
    run(C_BAD, -1, 1'b1, -1, -1, -1);
    run(C_JAL, -1, 1'b1, -1, -1, -1);
    run(C_I,   -1, 1'b1, 2, -1, -1);
    // randomized mix with occasional mid-instruction reset
    for (int n = 0; n < 400; n++) begin
      cls = $urandom_range(0, 6);
      cut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : -1;
      run(cls, cut, 1'($urandom_range(0, 3) == 0), -1, -1, -1);
    end
    done = 1'b1;
  end

  // Monitor: compare queued expectations against DUT outputs
  initial begin
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      ncyc++;
      if (q.size() > 0) begin
        it = q.pop_front();
        act = '{immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                irwrite, pcwrite, regwrite, memwrite, illegal};
        checks++;
        if (act !== it.e) begin
          errors++;
          $display("FAIL step%0d cyc%0d: got %h want %h (imm,srca,srcb,res,adr,aluc,ir,pc,rw,mw,ill)",
                   it.step, it.cyc, act, it.e);
        end
      end else if (done) begin
        checks++;
        if (checks - 1 != pushed) begin
          errors++;
          $display("FAIL drain: compared %0d want %0d", checks - 1, pushed);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
      if (ncyc > 50000) begin
        errors++;
        checks++;
        $display("FAIL timeout: cycles %0d want <= 50000", ncyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port op, input, 7 bits: instruction opcode.
REQ-004 SHALL have port funct3, input, 3 bits; port funct7b5, input, 1 bit (instr[30]).
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port immsrc, output, 2 bits: immediate-extender format select (00 I, 01 S, 10 B, 11 J).
REQ-007 SHALL have ports alusrca, alusrcb, resultsrc, outputs, 2 bits each; adrsrc, output, 1 bit; alucontrol, output, 3 bits.
REQ-008 SHALL have ports irwrite, pcwrite, regwrite, memwrite, outputs, 1 bit each.
REQ-009 SHALL have port illegal, output, 1 bit: illegal-opcode flag.

Function
REQ-010 SHALL be a Moore FSM, states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL; one transition per clk.
REQ-011 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (op 0000011/0100011), EXECUTER (0110011), EXECUTEI (0010011), BEQ (1100011), JAL (1101111), else FETCH; MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
REQ-012 op SHALL be sampled only in DECODE and MEMADR; changes elsewhere SHALL be ignored.
REQ-013 Per-state outputs (alusrca, alusrcb, aluop, resultsrc, other) SHALL be: FETCH 00,10,00,10, adrsrc=0, irwrite=1, pcupdate=1; DECODE 01,01,00; MEMADR 10,01,00; MEMREAD resultsrc=00, adrsrc=1; MEMWB resultsrc=01, regwrite=1; MEMWRITE resultsrc=00, adrsrc=1, memwrite=1; EXECUTER 10,00,10; EXECUTEI 10,01,10; ALUWB resultsrc=00, regwrite=1; BEQ 10,00,01, resultsrc=00, branch=1; JAL 01,10,00, resultsrc=00, pcupdate=1; unlisted signals 0.
REQ-014 pcwrite SHALL equal pcupdate OR (branch AND zero), combinationally.
REQ-015 alucontrol SHALL be: aluop 00->000 (add); 01->001 (sub); 10 by funct3: 000->001 if op[5]&funct7b5 else 000, 010->101, 110->011, 111->010, other->000; aluop 11->000.
REQ-016 immsrc SHALL decode from op in every state: 0100011->01, 1100011->10, 1101111->11, all else 00.
REQ-017 Instruction latency SHALL be lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4 cycles, FETCH to next FETCH.

Reset
REQ-018 reset high at a clk edge SHALL force state to FETCH, overriding any transition, including mid-instruction.
REQ-019 While reset is high, irwrite, pcwrite, regwrite, memwrite SHALL be 0; illegal SHALL clear to 0; other outputs SHALL show FETCH values.

Configuration
REQ-020 Macro MC_ILLEGAL_TRAP_EN defined: unknown opcode in DECODE SHALL go to ILLEGAL, which holds all write enables 0 and illegal=1 until reset.
REQ-021 MC_ILLEGAL_TRAP_EN undefined: unknown opcode SHALL return DECODE->FETCH; ILLEGAL state SHALL not exist; illegal SHALL be constant 0.

Verification
REQ-022 Reset then op=0000011 held: regwrite=1 on cycle 5 only; adrsrc=1 on cycle 4; next cycle irwrite=1.
REQ-023 op=1100011, zero=1: pcwrite=1 in BEQ cycle (cycle 3); repeat with zero=0: pcwrite=0 in cycle 3.
REQ-024 op=0110011, funct3=000, funct7b5=1: alucontrol=001 in EXECUTER; funct3=111: alucontrol=010.
REQ-025 op=0100011: immsrc=01, memwrite=1 only in cycle 4, regwrite never 1.
REQ-026 reset asserted in MEMREAD of lw: next state FETCH, regwrite never asserted for that lw.
REQ-027 op=1111111 with MC_ILLEGAL_TRAP_EN: illegal=1 from cycle 3, all write enables 0 until reset; without macro: FETCH at cycle 3, illegal=0.
